sram_rec_ctrl: RTL and testbench

Sequencing controller that sits directly upstream of the SRAM codec in the audio record/playback path. It turns a sample stream from the audio front end into single-word SRAM write cycles, and turns playback requests into two-cycle SRAM read cycles. It drives the codec's `on`, `read`, `write`, address and write-data inputs, and captures the codec's read data. It owns the record pointer, playback pointer and recorded length.

---
 rtl/sram_rec_ctrl_if.sv | 57 +++++
 rtl/sram_rec_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_sram_rec_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_rec_ctrl_if.sv
// sram_rec_ctrl_if
//   Bundles every non-clock, non-reset signal of sram_rec_ctrl.
//   slave  : controller side (sram_rec_ctrl).
//   master : environment side (audio front end, playback consumer, SRAM codec).
//
// Ports carried:
//   start_rec/start_play/stop  control pulses into the controller
//   in_sample/in_valid         record stream (strobe, no back-pressure)
//   out_req                    playback request level, sampled in PLAY_WAIT
//   out_sample/out_valid       playback result, out_valid pulses once per read
//   sram_on/read/write/addr/dataW/dataR  codec access signals
//   rec_len/busy/full/overrun/done       status
//   dbg_state                  current FSM state encoding
//
// Handshake semantics: in_valid is a strobe qualifying in_sample for exactly
// the cycle it is high; there is no ready -- a strobe that arrives while the
// controller is writing is dropped and flagged through overrun. out_req is
// acted upon only on edges where the controller sits in PLAY_WAIT; each
// accepted request yields exactly one out_valid pulse unless the read is
// abandoned by stop in its first cycle.
interface sram_rec_ctrl_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic              start_rec;
    logic              start_play;
    logic              stop;
    logic [DATA_W-1:0] in_sample;
    logic              in_valid;
    logic              out_req;
    logic [DATA_W-1:0] out_sample;
    logic              out_valid;
    logic              sram_on;
    logic              sram_read;
    logic              sram_write;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dataW;
    logic [DATA_W-1:0] sram_dataR;
    logic [ADDR_W:0]   rec_len;
    logic              busy;
    logic              full;
    logic              overrun;
    logic              done;
    logic [2:0]        dbg_state;

    modport slave (
        input  start_rec, start_play, stop, in_sample, in_valid, out_req, sram_dataR,
        output out_sample, out_valid, sram_on, sram_read, sram_write, sram_addr,
               sram_dataW, rec_len, busy, full, overrun, done, dbg_state
    );

    modport master (
        output start_rec, start_play, stop, in_sample, in_valid, out_req, sram_dataR,
        input  out_sample, out_valid, sram_on, sram_read, sram_write, sram_addr,
               sram_dataW, rec_len, busy, full, overrun, done, dbg_state
    );
endinterface

// File: rtl/sram_rec_ctrl.sv
// sram_rec_ctrl
//   Sequences record samples into single-cycle SRAM writes and playback
//   requests into two-cycle SRAM reads. Owns the record pointer, playback
//   pointer and recorded length.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  sram_rec_ctrl_if.slave (control, sample streams, codec, status)
//
// Every output is a flop; strobes for an access are computed from the next
// state so they are high exactly while the FSM sits in the access state.
module sram_rec_ctrl #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) (
    input logic           clk,
    input logic           rst,
    sram_rec_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REC_WAIT  = 3'd1,
        REC_WR    = 3'd2,
        PLAY_WAIT = 3'd3,
        PLAY_RD1  = 3'd4,
        PLAY_RD2  = 3'd5
    } state_t;

    // One past the last word address: the record pointer reaching this means full.
    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   rec_len_q, rec_len_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0] sram_dataW_q, sram_dataW_d;
    logic [DATA_W-1:0] out_sample_q, out_sample_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;
    logic              full_q, full_d;
    logic              overrun_q, overrun_d;
    logic              busy_q, busy_d;
    logic              sram_read_q, sram_read_d;
    logic              sram_write_q, sram_write_d;
    logic [ADDR_W:0]   wr_ptr_inc;

    assign wr_ptr_inc = wr_ptr_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rec_len_d    = rec_len_q;
        sram_addr_d  = sram_addr_q;
        sram_dataW_d = sram_dataW_q;
        out_sample_d = out_sample_q;
        out_valid_d  = 1'b0;
        done_d       = 1'b0;
        full_d       = full_q;
        overrun_d    = overrun_q;

        case (state_q)
            IDLE: begin
                if (bus.start_rec) begin
                    wr_ptr_d  = '0;
                    full_d    = 1'b0;
                    overrun_d = 1'b0;
                    state_d   = REC_WAIT;
                end else if (bus.start_play) begin
                    rd_ptr_d = '0;
                    state_d  = PLAY_WAIT;
                end
            end
            REC_WAIT: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (bus.in_valid) begin
                    // Address and data are set up here so they are stable
                    // for the whole write cycle.
                    sram_dataW_d = bus.in_sample;
                    sram_addr_d  = wr_ptr_q[ADDR_W-1:0];
                    state_d      = REC_WR;
                end
            end
            REC_WR: begin
                // The write always completes, even if stop arrives now.
                wr_ptr_d  = wr_ptr_inc;
                rec_len_d = wr_ptr_inc;
                if (bus.in_valid) begin
                    overrun_d = 1'b1;
                end
                if (wr_ptr_inc == CAPACITY) begin
                    full_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (bus.stop) begin
                    state_d = IDLE;
                end else begin
                    state_d = REC_WAIT;
                end
            end
            PLAY_WAIT: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (rd_ptr_q == rec_len_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (bus.out_req) begin
                    sram_addr_d = rd_ptr_q[ADDR_W-1:0];
                    state_d     = PLAY_RD1;
                end
            end
            PLAY_RD1: begin
                // Abandoning here leaves out_sample and rd_ptr untouched.
                state_d = bus.stop ? IDLE : PLAY_RD2;
            end
            PLAY_RD2: begin
                out_sample_d = bus.sram_dataR;
                out_valid_d  = 1'b1;
                rd_ptr_d     = rd_ptr_q + 1'b1;
                state_d      = bus.stop ? IDLE : PLAY_WAIT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d       = (state_d != IDLE);
        sram_write_d = (state_d == REC_WR);
        sram_read_d  = (state_d == PLAY_RD1) || (state_d == PLAY_RD2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rec_len_q    <= '0;
            sram_addr_q  <= '0;
            sram_dataW_q <= '0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            full_q       <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
            sram_read_q  <= 1'b0;
            sram_write_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rec_len_q    <= rec_len_d;
            sram_addr_q  <= sram_addr_d;
            sram_dataW_q <= sram_dataW_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
            done_q       <= done_d;
            full_q       <= full_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
            sram_read_q  <= sram_read_d;
            sram_write_q <= sram_write_d;
        end
    end

    assign bus.out_sample = out_sample_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.sram_on    = busy_q;
    assign bus.sram_read  = sram_read_q;
    assign bus.sram_write = sram_write_q;
    assign bus.sram_addr  = sram_addr_q;
    assign bus.sram_dataW = sram_dataW_q;
    assign bus.rec_len    = rec_len_q;
    assign bus.busy       = busy_q;
    assign bus.full       = full_q;
    assign bus.overrun    = overrun_q;
    assign bus.done       = done_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_sram_rec_ctrl.sv
// tb_sram_rec_ctrl
//   Bench for sram_rec_ctrl: a cycle table for record-then-play, directed
//   sequences for overrun, full (small ADDR_W instance), stop, priority,
//   empty playback and asynchronous reset.
module tb_sram_rec_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_rec_ctrl_if #(.ADDR_W(18), .DATA_W(16)) bus ();
  sram_rec_ctrl_if #(.ADDR_W(3), .DATA_W(16)) bus3 ();

  sram_rec_ctrl #(.ADDR_W(18), .DATA_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  sram_rec_ctrl #(.ADDR_W(3), .DATA_W(16)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // SRAM model for the main instance
  logic [15:0] mem [0:255];
  always @(posedge clk) if (bus.sram_write) mem[bus.sram_addr[7:0]] <= bus.sram_dataW;
  assign bus.sram_dataR = mem[bus.sram_addr[7:0]];
  assign bus3.sram_dataR = 16'h0;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- monitors / scoreboard ----------------
  int wr_cnt = 0, rd_cnt = 0, overlap = 0, dbl = 0, on_bad = 0;
  logic prev_wr = 1'b0;
  logic [18:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.sram_write) wr_cnt <= wr_cnt + 1;
    if (bus.sram_read) rd_cnt <= rd_cnt + 1;
    if (bus.sram_read && bus.sram_write) overlap <= overlap + 1;
    if (bus.sram_write && prev_wr) dbl <= dbl + 1;
    if (bus.sram_on !== bus.busy) on_bad <= on_bad + 1;
    prev_wr <= bus.sram_write;
  end

  always @(negedge clk) begin
    if (bus3.sram_write) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL full extra write: got addr %0h data %0h want no write", bus3.sram_addr, bus3.sram_dataW);
      end else begin
        check("full write", {bus3.sram_addr, bus3.sram_dataW}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  // in_bits = {start_rec, start_play, stop, in_valid, out_req}
  task automatic step(input logic [4:0] in_bits, input logic [15:0] din);
    {bus.start_rec, bus.start_play, bus.stop, bus.in_valid, bus.out_req} = in_bits;
    bus.in_sample = din;
    @(posedge clk);
    @(negedge clk);
    {bus.start_rec, bus.start_play, bus.stop, bus.in_valid, bus.out_req} = 5'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0]  in_bits;
    logic [15:0] din;
    logic [2:0]  e_st;
    logic [1:0]  e_wr_rd;
    logic [17:0] e_addr;
    logic [15:0] e_dw;
    logic [1:0]  e_ov_done;
    logic [15:0] e_out;
    logic [18:0] e_len;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [4:0] ib, input logic [15:0] din, input logic [2:0] st,
                     input logic [1:0] wr_rd, input logic [17:0] addr, input logic [15:0] dw,
                     input logic [1:0] ov_done, input logic [15:0] out, input logic [18:0] len);
    vec_t v;
    v.in_bits = ib; v.din = din; v.e_st = st; v.e_wr_rd = wr_rd; v.e_addr = addr;
    v.e_dw = dw; v.e_ov_done = ov_done; v.e_out = out; v.e_len = len;
    vecs.push_back(v);
  endtask

  int w0, r0;

  initial begin
    {bus.start_rec, bus.start_play, bus.stop, bus.in_valid, bus.out_req} = 5'b0;
    bus.in_sample = 16'h0;
    {bus3.start_rec, bus3.start_play, bus3.stop, bus3.in_valid, bus3.out_req} = 5'b0;
    bus3.in_sample = 16'h0;

    // record 0x1111/0x2222/0x3333 spaced 4 cycles, stop, then play back
    add(5'b10000, 16'h0,    3'd1, 2'b00, 18'd0, 16'h0,    2'b00, 16'h0,    19'd0);
    add(5'b00010, 16'h1111, 3'd2, 2'b10, 18'd0, 16'h1111, 2'b00, 16'h0,    19'd0);
    add(5'b00000, 16'h0,    3'd1, 2'b00, 18'd0, 16'h1111, 2'b00, 16'h0,    19'd1);
    add(5'b00000, 16'h0,    3'd1, 2'b00, 18'd0, 16'h1111, 2'b00, 16'h0,    19'd1);
    add(5'b00000, 16'h0,    3'd1, 2'b00, 18'd0, 16'h1111, 2'b00, 16'h0,    19'd1);
    add(5'b00010, 16'h2222, 3'd2, 2'b10, 18'd1, 16'h2222, 2'b00, 16'h0,    19'd1);
    add(5'b00000, 16'h0,    3'd1, 2'b00, 18'd1, 16'h2222, 2'b00, 16'h0,    19'd2);
    add(5'b00000, 16'h0,    3'd1, 2'b00, 18'd1, 16'h2222, 2'b00, 16'h0,    19'd2);
    add(5'b00000, 16'h0,    3'd1, 2'b00, 18'd1, 16'h2222, 2'b00, 16'h0,    19'd2);
    add(5'b00010, 16'h3333, 3'd2, 2'b10, 18'd2, 16'h3333, 2'b00, 16'h0,    19'd2);
    add(5'b00000, 16'h0,    3'd1, 2'b00, 18'd2, 16'h3333, 2'b00, 16'h0,    19'd3);
    add(5'b00100, 16'h0,    3'd0, 2'b00, 18'd2, 16'h3333, 2'b00, 16'h0,    19'd3);
    add(5'b01000, 16'h0,    3'd3, 2'b00, 18'd2, 16'h3333, 2'b00, 16'h0,    19'd3);
    add(5'b00001, 16'h0,    3'd4, 2'b01, 18'd0, 16'h3333, 2'b00, 16'h0,    19'd3);
    add(5'b00000, 16'h0,    3'd5, 2'b01, 18'd0, 16'h3333, 2'b00, 16'h0,    19'd3);
    add(5'b00000, 16'h0,    3'd3, 2'b00, 18'd0, 16'h3333, 2'b10, 16'h1111, 19'd3);
    add(5'b00001, 16'h0,    3'd4, 2'b01, 18'd1, 16'h3333, 2'b00, 16'h1111, 19'd3);
    add(5'b00000, 16'h0,    3'd5, 2'b01, 18'd1, 16'h3333, 2'b00, 16'h1111, 19'd3);
    add(5'b00000, 16'h0,    3'd3, 2'b00, 18'd1, 16'h3333, 2'b10, 16'h2222, 19'd3);
    add(5'b00001, 16'h0,    3'd4, 2'b01, 18'd2, 16'h3333, 2'b00, 16'h2222, 19'd3);
    add(5'b00000, 16'h0,    3'd5, 2'b01, 18'd2, 16'h3333, 2'b00, 16'h2222, 19'd3);
    add(5'b00000, 16'h0,    3'd3, 2'b00, 18'd2, 16'h3333, 2'b10, 16'h3333, 19'd3);
    add(5'b00001, 16'h0,    3'd0, 2'b00, 18'd2, 16'h3333, 2'b01, 16'h3333, 19'd3);
    add(5'b00000, 16'h0,    3'd0, 2'b00, 18'd2, 16'h3333, 2'b00, 16'h3333, 19'd3);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("reset state", {bus.dbg_state, bus.busy, bus.sram_on, bus.sram_read, bus.sram_write, bus.out_valid, bus.done}, 128'h0);
    check("reset data", {bus.sram_addr, bus.sram_dataW, bus.out_sample, bus.rec_len}, 128'h0);
    check("reset flags", {bus.full, bus.overrun}, 128'h0);

    // cycle table
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].in_bits, vecs[i].din);
      check($sformatf("vec %0d", i),
            {bus.dbg_state, bus.sram_write, bus.sram_read, bus.sram_addr, bus.sram_dataW,
             bus.out_valid, bus.done, bus.out_sample, bus.rec_len},
            {vecs[i].e_st, vecs[i].e_wr_rd, vecs[i].e_addr, vecs[i].e_dw,
             vecs[i].e_ov_done, vecs[i].e_out, vecs[i].e_len});
    end

    // full: ADDR_W=3, nine samples spaced 2 cycles
    bus3.start_rec = 1'b1;
    @(posedge clk); @(negedge clk);
    bus3.start_rec = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus3.in_sample = 16'h0100 + 16'(i);
      bus3.in_valid = 1'b1;
      if (i < 8) exp_q.push_back({3'(i), 16'h0100 + 16'(i)});
      @(posedge clk); @(negedge clk);
      bus3.in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      if (i == 7) begin
        check("full done pulse", {bus3.done, bus3.full, bus3.busy}, {1'b1, 1'b1, 1'b0});
        check("full rec_len", bus3.rec_len, 4'd8);
      end
    end
    check("full after 9th", {bus3.done, bus3.full, bus3.busy, bus3.rec_len}, {1'b0, 1'b1, 1'b0, 4'd8});

    // overrun: in_valid on two consecutive cycles
    w0 = wr_cnt;
    step(5'b10000, 16'h0);
    step(5'b00010, 16'hAAAA);
    step(5'b00010, 16'hBBBB);
    check("overrun flag", bus.overrun, 1'b1);
    check("overrun rec_len", bus.rec_len, 19'd1);
    check("overrun dataW", bus.sram_dataW, 16'hAAAA);
    step(5'b00100, 16'h0);
    check("overrun writes", wr_cnt - w0, 1);

    // stop sampled in REC_WR
    w0 = wr_cnt;
    step(5'b10000, 16'h0);
    check("start_rec clears overrun", bus.overrun, 1'b0);
    step(5'b00010, 16'h5555);
    check("stop rec_wr write", {bus.dbg_state, bus.sram_write, bus.sram_addr}, {3'd2, 1'b1, 18'd0});
    step(5'b00100, 16'h0);
    check("stop rec_wr end", {bus.dbg_state, bus.done, bus.rec_len}, {3'd0, 1'b0, 19'd1});
    step(5'b00000, 16'h0);
    check("stop rec_wr writes", wr_cnt - w0, 1);

    // stop sampled in PLAY_RD1
    step(5'b01000, 16'h0);
    step(5'b00001, 16'h0);
    check("rd1 reading", {bus.dbg_state, bus.sram_read}, {3'd4, 1'b1});
    step(5'b00100, 16'h0);
    check("stop rd1", {bus.dbg_state, bus.sram_read, bus.out_valid, bus.done, bus.out_sample}, {3'd0, 1'b0, 1'b0, 1'b0, 16'h3333});
    step(5'b00000, 16'h0);
    check("stop rd1 after", {bus.out_valid, bus.out_sample}, {1'b0, 16'h3333});

    // stop sampled in PLAY_RD2
    step(5'b01000, 16'h0);
    step(5'b00001, 16'h0);
    step(5'b00000, 16'h0);
    step(5'b00100, 16'h0);
    check("stop rd2", {bus.dbg_state, bus.out_valid, bus.done, bus.out_sample}, {3'd0, 1'b1, 1'b0, 16'h5555});

    // priority and start ignored outside IDLE
    step(5'b11000, 16'h0);
    check("rec wins", bus.dbg_state, 3'd1);
    step(5'b01000, 16'h0);
    check("start_play ignored", bus.dbg_state, 3'd1);
    step(5'b00100, 16'h0);
    check("priority stop", {bus.dbg_state, bus.rec_len}, {3'd0, 19'd1});

    // asynchronous reset during PLAY_RD2
    step(5'b01000, 16'h0);
    step(5'b00001, 16'h0);
    step(5'b00000, 16'h0);
    check("in rd2", {bus.dbg_state, bus.sram_read}, {3'd5, 1'b1});
    rst = 1'b1;
    #1;
    check("async rst", {bus.dbg_state, bus.sram_read, bus.busy, bus.out_valid, bus.sram_on}, 128'h0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("rst loses length", bus.rec_len, 19'd0);

    // empty playback right after reset
    r0 = rd_cnt;
    step(5'b01000, 16'h0);
    check("empty play wait", bus.dbg_state, 3'd3);
    step(5'b00001, 16'h0);
    check("empty play done", {bus.dbg_state, bus.done, bus.sram_read}, {3'd0, 1'b1, 1'b0});
    step(5'b00000, 16'h0);
    check("empty play reads", rd_cnt - r0, 0);
    check("empty play done once", bus.done, 1'b0);

    // whole-run invariants
    check("read/write overlap", overlap, 0);
    check("multi-cycle write", dbl, 0);
    check("sram_on vs busy", on_bad, 0);
    check("scoreboard drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
